// File: rtl/rast_sched_pkg.sv
// Shared types and constants for the rast triangle issue scheduler.
// Field widths live here so the hold-register struct and the port widths always agree.
package rast_sched_pkg;

   localparam int SIGFIG   = 24;
   localparam int VERTS    = 3;
   localparam int AXIS     = 3;
   localparam int COLORS   = 3;
   localparam int TRI_W    = VERTS * AXIS * SIGFIG;
   localparam int COLOR_W  = COLORS * SIGFIG;
   localparam int SCREEN_W = 2 * SIGFIG;

   localparam logic [3:0] SS_1 = 4'b0001;
   localparam logic [3:0] SS_2 = 4'b0010;
   localparam logic [3:0] SS_4 = 4'b0100;
   localparam logic [3:0] SS_8 = 4'b1000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      APPLY = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [TRI_W-1:0]    tri_pos;
      logic [COLOR_W-1:0]  color;
      logic [SCREEN_W-1:0] screen;
   } tri_bundle_t;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/rast_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and advances the pointer past the winner only when the grant is actually used.
module rast_rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   output logic [NREQ-1:0] grant
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;

   // Search by rotational distance from the pointer so the lowest distance wins.
   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int d = 0; d < NREQ; d++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (((i - int'(ptr_q) + NREQ) % NREQ) == d)) begin
               grant[i] = 1'b1;
               found    = 1'b1;
               if (enable) begin
                  ptr_d = PW'((i + 1) % NREQ);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rast_tri_sched.sv
// Issue scheduler in front of rast: arbitrates triangle sources into a single hold slot
// and changes subSample only once the rast pipeline has been proven empty.
//
//   state | meaning
//   RUN   | normal issue; requesters arbitrated into the hold slot
//   DRAIN | cfg pending; no new grants, wait for DRAIN_CYC clean empty cycles
//   APPLY | one cycle: apply subSample if one-hot, pulse cfg_ready (and cfg_err)
module rast_tri_sched
   import rast_sched_pkg::*;
#(
   parameter int         NREQ      = 2,
   parameter int         DRAIN_CYC = 6,
   parameter logic [3:0] SS_RST    = SS_1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*TRI_W-1:0]    req_tri,
   input  logic [NREQ*COLOR_W-1:0]  req_color,
   input  logic [NREQ*SCREEN_W-1:0] req_screen,
   input  logic                     cfg_valid,
   input  logic [3:0]               cfg_subSample,
   output logic                     cfg_ready,
   output logic                     cfg_err,
   output logic                     validTri_R10H,
   output logic [TRI_W-1:0]         tri_R10S,
   output logic [COLOR_W-1:0]       color_R10U,
   output logic [SCREEN_W-1:0]      screen_RnnnnS,
   output logic [3:0]               subSample_RnnnnU,
   input  logic                     halt_RnnnnL,
   output logic [15:0]              tri_count
);

   localparam int DCW = $clog2(DRAIN_CYC + 1);

   sched_state_t   state_q, state_d;
   logic           held_q, held_d;
   tri_bundle_t    slot_q, slot_d;
   logic [3:0]     ss_q, ss_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [DCW-1:0] drain_q, drain_d;

   logic            accept;
   logic            load_en;
   logic            load;
   logic [NREQ-1:0] grant;
   tri_bundle_t     sel_bundle;

   assign accept = held_q & halt_RnnnnL;

   // rst gates the grant path so req_ready reads zero for the whole reset window.
   assign load_en = rst & (state_q == RUN) & ~cfg_valid & (~held_q | accept);
   assign load    = load_en & (|req_valid);

   rast_rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst),
      .req   (req_valid),
      .enable(load_en),
      .grant (grant)
   );

   assign req_ready = grant & {NREQ{load_en}};

   always_comb begin
      sel_bundle = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_bundle.tri_pos = sel_bundle.tri_pos
                            | ({TRI_W{grant[i]}} & req_tri[i*TRI_W +: TRI_W]);
         sel_bundle.color   = sel_bundle.color
                            | ({COLOR_W{grant[i]}} & req_color[i*COLOR_W +: COLOR_W]);
         sel_bundle.screen  = sel_bundle.screen
                            | ({SCREEN_W{grant[i]}} & req_screen[i*SCREEN_W +: SCREEN_W]);
      end
   end

   always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      slot_d    = slot_q;
      ss_d      = ss_q;
      cnt_d     = cnt_q;
      drain_d   = drain_q;
      cfg_ready = 1'b0;
      cfg_err   = 1'b0;

      if (accept) begin
         held_d = 1'b0;
         cnt_d  = cnt_q + 16'd1;
      end
      if (load) begin
         held_d = 1'b1;
         slot_d = sel_bundle;
      end

      case (state_q)
         RUN: begin
            drain_d = '0;
            if (cfg_valid) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Only an empty slot with rast ready and nothing issued counts as proof of empty.
            if (accept || !halt_RnnnnL) begin
               drain_d = '0;
            end else if (!held_q) begin
               if (drain_q == DCW'(DRAIN_CYC - 1)) begin
                  drain_d = '0;
                  state_d = APPLY;
               end else begin
                  drain_d = drain_q + DCW'(1);
               end
            end
         end
         APPLY: begin
            cfg_ready = 1'b1;
            if (is_onehot4(cfg_subSample)) begin
               ss_d = cfg_subSample;
            end else begin
               cfg_err = 1'b1;
            end
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         held_q  <= 1'b0;
         slot_q  <= '0;
         ss_q    <= SS_RST;
         cnt_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         slot_q  <= slot_d;
         ss_q    <= ss_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end

   assign validTri_R10H    = accept;
   assign tri_R10S         = slot_q.tri_pos;
   assign color_R10U       = slot_q.color;
   assign screen_RnnnnS    = slot_q.screen;
   assign subSample_RnnnnU = ss_q;
   assign tri_count        = cnt_q;

endmodule

// File: tb/tb_rast_tri_sched.sv
// Scoreboard bench for rast_tri_sched: stimulus pushes expected triangles and cfg outcomes,
// a negedge monitor pops and compares whenever the DUT issues a triangle or acks a cfg.
module tb_rast_tri_sched;
   import rast_sched_pkg::*;

   localparam int NREQ = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ*TRI_W-1:0]    req_tri;
   logic [NREQ*COLOR_W-1:0]  req_color;
   logic [NREQ*SCREEN_W-1:0] req_screen;
   logic                     cfg_valid;
   logic [3:0]               cfg_ss;
   logic                     cfg_ready;
   logic                     cfg_err;
   logic                     validTri_R10H;
   logic [TRI_W-1:0]         tri_R10S;
   logic [COLOR_W-1:0]       color_R10U;
   logic [SCREEN_W-1:0]      screen_RnnnnS;
   logic [3:0]               subSample_RnnnnU;
   logic                     halt_RnnnnL;
   logic [15:0]              tri_count;

   int              n_tests = 0;
   int              n_fail  = 0;
   tri_bundle_t     exp_q[$];
   bit              err_q[$];
   int              cnt_req[NREQ];
   logic [NREQ-1:0] xfer_n = '0;
   logic            in_cfg = 1'b0;

   always #5 clk = ~clk;

   rast_tri_sched #(
      .NREQ(NREQ),
      .DRAIN_CYC(6),
      .SS_RST(4'b0001)
   ) dut (
      .clk             (clk),
      .rst             (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_tri         (req_tri),
      .req_color       (req_color),
      .req_screen      (req_screen),
      .cfg_valid       (cfg_valid),
      .cfg_subSample   (cfg_ss),
      .cfg_ready       (cfg_ready),
      .cfg_err         (cfg_err),
      .validTri_R10H   (validTri_R10H),
      .tri_R10S        (tri_R10S),
      .color_R10U      (color_R10U),
      .screen_RnnnnS   (screen_RnnnnS),
      .subSample_RnnnnU(subSample_RnnnnU),
      .halt_RnnnnL     (halt_RnnnnL),
      .tri_count       (tri_count)
   );

   // Requester i's k-th triangle: every field tagged {source, sequence, field index}.
   function automatic tri_bundle_t pay(input int i, input int k);
      tri_bundle_t b;
      b = '0;
      for (int j = 0; j < VERTS*AXIS; j++) b.tri_pos[j*SIGFIG +: SIGFIG] = {8'(i), 8'(k), 8'(j)};
      for (int j = 0; j < COLORS; j++)     b.color[j*SIGFIG +: SIGFIG]   = {8'hC0 | 8'(i), 8'(k), 8'(j)};
      for (int j = 0; j < 2; j++)          b.screen[j*SIGFIG +: SIGFIG]  = {8'h50 | 8'(i), 8'(k), 8'(j)};
      return b;
   endfunction

   for (genvar g = 0; g < NREQ; g++) begin : g_req
      tri_bundle_t pb;
      assign pb = pay(g, cnt_req[g]);
      assign req_tri[g*TRI_W +: TRI_W]          = pb.tri_pos;
      assign req_color[g*COLOR_W +: COLOR_W]    = pb.color;
      assign req_screen[g*SCREEN_W +: SCREEN_W] = pb.screen;
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Each requester advances to its next triangle after a transfer.
   always @(negedge clk) xfer_n = req_valid & req_ready;
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         for (int i = 0; i < NREQ; i++) if (xfer_n[i]) cnt_req[i]++;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("req_ready_onehot", ($countones(req_ready) <= 1), 1'b1);
         check("cfg_err_without_ready", cfg_err & ~cfg_ready, 1'b0);
         if (in_cfg) check("no_grant_during_cfg", req_ready, '0);
         if (validTri_R10H) begin
            check("valid_only_when_halt_high", halt_RnnnnL, 1'b1);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_tri: actual %0h required none", tri_R10S);
            end else begin
               tri_bundle_t e;
               e = exp_q.pop_front();
               check("tri_issue", {tri_R10S, color_R10U, screen_RnnnnS}, e);
            end
         end
         if (cfg_ready) begin
            if (err_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_cfg_ready: actual 1 required 0");
            end else begin
               bit ee;
               ee = err_q.pop_front();
               check("cfg_err", cfg_err, ee);
            end
         end
      end
   end

   task automatic do_cfg(input logic [3:0] v, input int glitch, input int exp_n);
      int n;
      bit seen;
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_ss    = v;
      halt_RnnnnL = 1'b1;
      in_cfg    = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         halt_RnnnnL = (n == glitch) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (cfg_ready) seen = 1'b1;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL cfg_timeout: actual no cfg_ready in %0d cycles required %0d", n, exp_n);
      end else begin
         check("cfg_latency", n, exp_n);
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      req_valid = '0;
      in_cfg    = 1'b0;
      @(negedge clk);
      check("cfg_ready_pulse", cfg_ready, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NREQ; i++) cnt_req[i] = 0;
      req_valid   = 2'b11;
      halt_RnnnnL = 1'b1;
      cfg_valid   = 1'b0;
      cfg_ss      = 4'b0000;

      // Reset state with requesters and rast both active
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", validTri_R10H, 1'b0);
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_cfg_ready", cfg_ready, 1'b0);
      check("rst_cfg_err", cfg_err, 1'b0);
      check("rst_subsample", subSample_RnnnnU, 4'b0001);
      check("rst_tri_count", tri_count, 16'd0);
      check("rst_tri_out", tri_R10S, '0);
      req_valid   = '0;
      halt_RnnnnL = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Both requesters, rast always ready: alternating grants, one triangle per cycle
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(pay(0, k));
         exp_q.push_back(pay(1, k));
      end
      @(posedge clk); #1;
      halt_RnnnnL = 1'b1;
      req_valid   = 2'b11;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         if (k == 7) begin
            #1;
            req_valid = '0;
         end
         @(negedge clk);
         check("t2_valid_every_cycle", validTri_R10H, 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      check("t2_tri_count", tri_count, 16'd8);
      check("t2_idle", validTri_R10H, 1'b0);

      // rast halted with the slot full: nothing moves, then the same triangle issues once
      exp_q.push_back(pay(0, 4));
      exp_q.push_back(pay(1, 4));
      @(posedge clk); #1;
      halt_RnnnnL = 1'b0;
      req_valid   = 2'b01;
      @(posedge clk); #1;
      req_valid   = 2'b10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t3_stall_valid", validTri_R10H, 1'b0);
         check("t3_stall_ready", req_ready, 2'b00);
         check("t3_stall_data", {tri_R10S, color_R10U, screen_RnnnnS}, pay(0, 4));
         @(posedge clk);
      end
      #1;
      halt_RnnnnL = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      check("t3_tri_count", tri_count, 16'd10);
      check("t3_queue_empty", exp_q.size(), 0);

      // cfg with a triangle held: triangle drains, then 6 idle cycles, then APPLY
      exp_q.push_back(pay(0, 5));
      err_q.push_back(1'b0);
      @(posedge clk); #1;
      halt_RnnnnL = 1'b0;
      req_valid   = 2'b01;
      @(posedge clk); #1;
      req_valid   = 2'b11;
      do_cfg(4'b0100, 0, 7);
      check("t4_subsample", subSample_RnnnnU, 4'b0100);
      check("t4_tri_count", tri_count, 16'd11);

      // Non-one-hot request: acked with error, value unchanged
      err_q.push_back(1'b1);
      do_cfg(4'b0110, 0, 7);
      check("t5_subsample_kept", subSample_RnnnnU, 4'b0100);

      // halt drops at drain count 5: counter restarts, APPLY only after 6 clean cycles
      err_q.push_back(1'b0);
      do_cfg(4'b1000, 6, 13);
      check("t6_subsample", subSample_RnnnnU, 4'b1000);

      // Reset mid-traffic with a held triangle and a pending cfg
      @(posedge clk); #1;
      halt_RnnnnL = 1'b0;
      req_valid   = 2'b11;
      @(posedge clk); #1;
      cfg_ss    = 4'b0010;
      cfg_valid = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      halt_RnnnnL = 1'b1;
      #2;
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      #1;
      check("t1_valid", validTri_R10H, 1'b0);
      check("t1_req_ready", req_ready, 2'b00);
      check("t1_cfg_ready", cfg_ready, 1'b0);
      check("t1_subsample", subSample_RnnnnU, 4'b0001);
      check("t1_tri_count", tri_count, 16'd0);
      check("t1_tri_out", {tri_R10S, color_R10U, screen_RnnnnS}, '0);
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // After reset the pointer is back at requester 0 and the old cfg is gone
      exp_q.push_back(pay(0, 6));
      exp_q.push_back(pay(1, 6));
      @(posedge clk); #1;
      req_valid = 2'b11;
      @(posedge clk);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_tri_count", tri_count, 16'd2);
      check("post_rst_subsample", subSample_RnnnnU, 4'b0001);
      check("final_tri_queue_empty", exp_q.size(), 0);
      check("final_cfg_queue_empty", err_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
